uc_arb: RTL and testbench
=========================

UC_ARB -- requirements
Module: uc_arb

Interface
REQ-001 Parameter NUM_PE, default 4, number of BCP engines served.
REQ-002 Parameter FIFO_DEPTH, default 8, implication queue entries (power of 2).
REQ-003 Parameter VAR_MAX, default 63, largest variable index.
REQ-004 Parameter LIT_W, default $clog2(VAR_MAX)+1, two's-complement literal width; literal 0 is reserved and never valid.
REQ-005 Parameter PTR_W, default 8, clause-queue pointer width.
REQ-006 The module SHALL have one clock and an asynchronous active-high reset:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-high despite the suffix
REQ-007 PE-facing ports:
- pe_imply_valid  in  NUM_PE  implication strobe per PE
- pe_imply_lit  in  NUM_PE*LIT_W  implied literal per PE
- pe_conflict  in  NUM_PE  clause conflict per PE
- pe_halt  out  1  freeze all PEs
- newLit  out  LIT_W  literal broadcast to all PEs
- newLitValid  out  1  broadcast valid
- newLitHeadPtr  out  NUM_PE*PTR_W  per-PE watch-list head for newLit
- newLitAccept  in  NUM_PE  per-PE ready
REQ-008 Solver-facing ports:
- dec_valid  in  1  decision literal offer
- dec_lit  in  LIT_W  decision literal
- dec_ready  out  1  decision accepted when high with dec_valid
- cfg_we  in  1  head-pointer table write
- cfg_pe  in  $clog2(NUM_PE)  table PE select
- cfg_lit  in  LIT_W  table literal select
- cfg_ptr  in  PTR_W  head pointer to write
- clr  in  1  synchronous clear after conflict/backtrack
- conflict  out  1  sticky conflict flag
- quiescent  out  1  propagation complete

Function
REQ-009 The module SHALL implement states IDLE, RUN, CONFLICT; reset enters IDLE.
REQ-010 Capture: each cycle with pe_halt=0 and state!=CONFLICT, every PE i with pe_imply_valid[i]=1 and a nonzero literal SHALL load its literal into one-entry slot i.
REQ-011 pe_halt SHALL be combinationally 1 whenever any slot is occupied or state==CONFLICT.
REQ-012 Drain: each cycle, at most one occupied slot SHALL be processed, chosen round-robin starting after the last-drained index; no slot is processed when the FIFO is full.
REQ-013 Dedup: a literal-indexed queued bitmap (2*VAR_MAX bits) SHALL be kept; a drained literal already queued is dropped; one whose negation is queued raises conflict; otherwise it is pushed and its bit set.
REQ-014 dec_ready SHALL be 1 only when state!=CONFLICT, no slot is occupied and the FIFO is not full; accepted decisions follow the REQ-013 rules.
REQ-015 Push requires a not-full registered count; a push and a pop in the same cycle SHALL both occur with the count unchanged.
REQ-016 newLitValid SHALL equal (FIFO non-empty AND state==RUN); newLit is the FIFO head; newLitHeadPtr[i] is a combinational read of table[i][newLit].
REQ-017 Pop SHALL occur only in a cycle where newLitValid=1 and newLitAccept is all ones; no partial broadcast.
REQ-018 Latency: implication at cycle t yields newLitValid at t+2 on an empty FIFO; a decision accepted at t yields newLitValid at t+1.
REQ-019 IDLE->RUN on any push; RUN->IDLE when FIFO and slots are empty and no implication is captured that cycle.
REQ-020 Any pe_conflict bit, or a dedup conflict, SHALL move the state to CONFLICT next cycle; the FIFO and slots are flushed, conflict=1 and newLitValid=0 until clr.
REQ-021 clr SHALL have priority over all events: it flushes the FIFO, slots and bitmap, moves to IDLE, and leaves the table intact.
REQ-022 A table write SHALL take effect the following cycle in any state; unwritten entries read 0.
REQ-023 quiescent SHALL equal (state==IDLE AND newLitAccept all ones).

Reset
REQ-024 Asserting rst_n SHALL immediately clear the FIFO, slots, bitmap, table and round-robin pointer, and set conflict=0 and state=IDLE; newLitValid=0, pe_halt=0 and dec_ready=1 follow combinationally.
REQ-025 Reset asserted mid-RUN SHALL discard all pending literals without emitting a broadcast.

Verification
REQ-026 Write table[0..3][5]=0x10..0x13; dec_lit=5 -> next cycle newLit=5 with ptrs 0x10..0x13; all accept -> pop, IDLE, quiescent=1.
REQ-027 PE0 and PE2 imply -3 in the same cycle -> pe_halt=1 for 2 cycles, exactly one broadcast of -3.
REQ-028 PE1 implies 7 and PE3 implies -7 in the same cycle -> conflict=1 by t+3, newLitValid=0; clr -> IDLE; re-deciding 7 is accepted.
REQ-029 Hold newLitAccept=0 and fill 8 entries -> dec_ready=0 and slot held; release accept -> entries emitted in FIFO order, then the slot literal.
REQ-030 pe_conflict[2]=1 during RUN with 3 entries queued -> CONFLICT next cycle and FIFO empty; async reset mid-RUN -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/uc_arb.sv
// uc_arb: collects implications from NUM_PE BCP engines and solver decisions.
// It removes duplicate literals, detects complementary literals, and broadcasts
// one literal at a time to every engine. With each literal it also sends the
// watch-list head pointer that each engine keeps for that literal.
`timescale 1ns/1ps

module uc_arb #(
    parameter int unsigned NUM_PE     = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned VAR_MAX    = 63,
    parameter int unsigned LIT_W      = $clog2(VAR_MAX) + 1,
    parameter int unsigned PTR_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,          // active-high async reset

    // engine side
    input  logic [NUM_PE-1:0]          pe_imply_valid,
    input  logic [NUM_PE*LIT_W-1:0]    pe_imply_lit,
    input  logic [NUM_PE-1:0]          pe_conflict,
    output logic                       pe_halt,
    output logic [LIT_W-1:0]           newLit,
    output logic                       newLitValid,
    output logic [NUM_PE*PTR_W-1:0]    newLitHeadPtr,
    input  logic [NUM_PE-1:0]          newLitAccept,

    // solver side
    input  logic                       dec_valid,
    input  logic [LIT_W-1:0]           dec_lit,
    output logic                       dec_ready,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_PE)-1:0]  cfg_pe,
    input  logic [LIT_W-1:0]           cfg_lit,
    input  logic [PTR_W-1:0]           cfg_ptr,
    input  logic                       clr,
    output logic                       conflict,
    output logic                       quiescent
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned BM_N  = 2 * VAR_MAX;
    localparam int unsigned BM_W  = $clog2(BM_N);
    localparam int unsigned IDX_W = $clog2(NUM_PE);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_CONFLICT = 2'd2
    } state_t;

    // Magnitude of a two's-complement literal.
    function automatic logic [LIT_W-1:0] lit_mag(input logic [LIT_W-1:0] l);
        return l[LIT_W-1] ? -l : l;
    endfunction

    // A literal is usable when it is nonzero and names a variable in 1..VAR_MAX.
    function automatic logic lit_ok(input logic [LIT_W-1:0] l);
        logic [LIT_W-1:0] m;
        m = lit_mag(l);
        return (m != '0) && (32'(m) <= VAR_MAX);
    endfunction

    // Bitmap/table slot: positive literals at 0..VAR_MAX-1, negative ones above.
    function automatic logic [BM_W-1:0] bm_idx(input logic [LIT_W-1:0] l,
                                               input logic             neg);
        return BM_W'(32'(lit_mag(l)) - 32'd1 + (neg ? VAR_MAX : 32'd0));
    endfunction

    function automatic logic [BM_W-1:0] own_idx(input logic [LIT_W-1:0] l);
        return bm_idx(l, l[LIT_W-1]);
    endfunction

    function automatic logic [BM_W-1:0] opp_idx(input logic [LIT_W-1:0] l);
        return bm_idx(l, !l[LIT_W-1]);
    endfunction

    state_t                 state, state_nxt;

    logic [NUM_PE-1:0]      slot_valid;
    logic [LIT_W-1:0]       slot_lit [NUM_PE];
    logic [LIT_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [BM_N-1:0]        queued;
    logic [PTR_W-1:0]       head_tbl [NUM_PE][BM_N];
    logic [IDX_W-1:0]       rr_last;
    logic                   conflict_q;

    logic                   fifo_full, fifo_empty;
    logic [NUM_PE-1:0]      capture;
    logic                   drain_found, drain_take;
    logic [IDX_W-1:0]       drain_sel;
    logic [NUM_PE-1:0]      drain_mask;
    logic                   cand_valid;
    logic [LIT_W-1:0]       cand_lit;
    logic                   push, pop, ded_conflict, go_conflict;
    logic [CW-1:0]          count_after;
    logic [NUM_PE-1:0]      slots_after;

    // Status outputs are combinational views of the registered state.
    assign fifo_full   = (count == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count == '0);
    assign pe_halt     = (|slot_valid) || (state == ST_CONFLICT);
    assign dec_ready   = (state != ST_CONFLICT) && !(|slot_valid) && !fifo_full;
    assign newLitValid = !fifo_empty && (state == ST_RUN);
    assign newLit      = fifo_mem[rd_ptr];
    assign pop         = newLitValid && (&newLitAccept);
    assign quiescent   = (state == ST_IDLE) && (&newLitAccept);
    assign conflict    = conflict_q;

    // Head pointer lookup for the literal currently broadcast.
    always_comb begin
        newLitHeadPtr = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (lit_ok(newLit)) begin
                newLitHeadPtr[i*PTR_W +: PTR_W] = head_tbl[i][own_idx(newLit)];
            end
        end
    end

    // Capture new implications only while all slots are empty and not halted.
    always_comb begin
        capture = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (!pe_halt && pe_imply_valid[i] &&
                (pe_imply_lit[i*LIT_W +: LIT_W] != '0)) begin
                capture[i] = 1'b1;
            end
        end
    end

    // Round-robin pick of the next occupied slot, starting after the last one drained.
    always_comb begin
        logic [IDX_W-1:0] c;
        c           = '0;
        drain_found = 1'b0;
        drain_sel   = rr_last;
        for (int unsigned k = 1; k <= NUM_PE; k++) begin
            c = IDX_W'((32'(rr_last) + k) % NUM_PE);
            if (!drain_found && slot_valid[c]) begin
                drain_found = 1'b1;
                drain_sel   = c;
            end
        end
    end

    // Select the literal to process, then drop it, push it, or flag a conflict.
    always_comb begin
        drain_take   = drain_found && !fifo_full;
        drain_mask   = '0;
        cand_valid   = 1'b0;
        cand_lit     = '0;
        push         = 1'b0;
        ded_conflict = 1'b0;
        if (drain_take) begin
            drain_mask[drain_sel] = 1'b1;
            cand_valid            = 1'b1;
            cand_lit              = slot_lit[drain_sel];
        end else if (dec_valid && dec_ready) begin
            cand_valid = 1'b1;
            cand_lit   = dec_lit;
        end
        if (cand_valid && lit_ok(cand_lit)) begin
            if (queued[opp_idx(cand_lit)]) begin
                ded_conflict = 1'b1;
            end else if (!queued[own_idx(cand_lit)]) begin
                push = 1'b1;
            end
        end
        go_conflict = (state != ST_CONFLICT) && ((|pe_conflict) || ded_conflict);
        count_after = count + CW'(push) - CW'(pop);
        slots_after = (slot_valid & ~drain_mask) | capture;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; clear overrides everything.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go_conflict)  state_nxt = ST_CONFLICT;
                    else if (push)    state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (go_conflict) begin
                        state_nxt = ST_CONFLICT;
                    end else if ((count_after == '0) && (slots_after == '0)) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_CONFLICT: state_nxt = ST_CONFLICT;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // Slots, queue, dedup bitmap and sticky conflict flag.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            slot_valid <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            queued     <= '0;
            rr_last    <= '0;
            conflict_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_PE; i++) slot_lit[i] <= '0;
            for (int unsigned j = 0; j < FIFO_DEPTH; j++) fifo_mem[j] <= '0;
        end else if (clr || go_conflict) begin
            slot_valid <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            if (clr) begin
                queued     <= '0;
                conflict_q <= 1'b0;
            end else begin
                conflict_q <= 1'b1;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr]          <= cand_lit;
                wr_ptr                    <= wr_ptr + AW'(1);
                queued[own_idx(cand_lit)] <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_after;
            slot_valid <= slots_after;
            for (int unsigned i = 0; i < NUM_PE; i++) begin
                if (capture[i]) slot_lit[i] <= pe_imply_lit[i*LIT_W +: LIT_W];
            end
            if (drain_take) begin
                rr_last <= drain_sel;
            end
        end
    end

    // Per-engine watch-list head table. Clear does not touch it; reset zeroes it.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned p = 0; p < NUM_PE; p++) begin
                for (int unsigned e = 0; e < BM_N; e++) head_tbl[p][e] <= '0;
            end
        end else if (cfg_we && lit_ok(cfg_lit)) begin
            head_tbl[cfg_pe][own_idx(cfg_lit)] <= cfg_ptr;
        end
    end

endmodule

// File: tb/tb_uc_arb.sv
// Directed bench for uc_arb. A scoreboard queue holds the expected broadcasts.
`timescale 1ns/1ps

module tb_uc_arb;

    localparam int unsigned NUM_PE = 4;
    localparam int unsigned LIT_W  = 7;
    localparam int unsigned PTR_W  = 8;

    typedef struct packed {
        logic [LIT_W-1:0]        lit;
        logic [NUM_PE*PTR_W-1:0] ptrs;
    } bcast_t;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_PE-1:0]          pe_imply_valid;
    logic [NUM_PE*LIT_W-1:0]    pe_imply_lit;
    logic [NUM_PE-1:0]          pe_conflict;
    logic                       pe_halt;
    logic [LIT_W-1:0]           newLit;
    logic                       newLitValid;
    logic [NUM_PE*PTR_W-1:0]    newLitHeadPtr;
    logic [NUM_PE-1:0]          newLitAccept;
    logic                       dec_valid;
    logic [LIT_W-1:0]           dec_lit;
    logic                       dec_ready;
    logic                       cfg_we;
    logic [1:0]                 cfg_pe;
    logic [LIT_W-1:0]           cfg_lit;
    logic [PTR_W-1:0]           cfg_ptr;
    logic                       clr;
    logic                       conflict;
    logic                       quiescent;

    bcast_t sb[$];
    int     checks   = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    uc_arb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pe_imply_valid (pe_imply_valid),
        .pe_imply_lit   (pe_imply_lit),
        .pe_conflict    (pe_conflict),
        .pe_halt        (pe_halt),
        .newLit         (newLit),
        .newLitValid    (newLitValid),
        .newLitHeadPtr  (newLitHeadPtr),
        .newLitAccept   (newLitAccept),
        .dec_valid      (dec_valid),
        .dec_lit        (dec_lit),
        .dec_ready      (dec_ready),
        .cfg_we         (cfg_we),
        .cfg_pe         (cfg_pe),
        .cfg_lit        (cfg_lit),
        .cfg_ptr        (cfg_ptr),
        .clr            (clr),
        .conflict       (conflict),
        .quiescent      (quiescent)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bcast(input logic [LIT_W-1:0] lit, input logic [NUM_PE*PTR_W-1:0] ptrs);
        bcast_t e;
        e.lit  = lit;
        e.ptrs = ptrs;
        sb.push_back(e);
    endtask

    function automatic logic [LIT_W-1:0] neg_lit(input int v);
        return LIT_W'(-v);
    endfunction

    // Every accepted broadcast must match the oldest expected entry.
    always @(negedge clk) begin
        bcast_t e;
        if (!rst_n && newLitValid && (&newLitAccept)) begin
            if (sb.size() == 0) begin
                chk("bcast_unexpected", 64'(newLit), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("bcast_lit", 64'(newLit), 64'(e.lit));
                chk("bcast_ptrs", 64'(newLitHeadPtr), 64'(e.ptrs));
            end
        end
    end

    initial begin
        rst_n          = 1'b1;
        pe_imply_valid = '0;
        pe_imply_lit   = '0;
        pe_conflict    = '0;
        newLitAccept   = '1;
        dec_valid      = 1'b0;
        dec_lit        = '0;
        cfg_we         = 1'b0;
        cfg_pe         = '0;
        cfg_lit        = '0;
        cfg_ptr        = '0;
        clr            = 1'b0;

        // reset values
        #1;
        chk("rst_halt",   64'(pe_halt),     64'(0));
        chk("rst_valid",  64'(newLitValid), 64'(0));
        chk("rst_ready",  64'(dec_ready),   64'(1));
        chk("rst_conf",   64'(conflict),    64'(0));
        chk("rst_quiesc", 64'(quiescent),   64'(1));
        tick();
        tick();
        rst_n = 1'b0;
        tick();

        // head table for literal 5, then a decision of 5
        for (int i = 0; i < 4; i++) begin
            cfg_we  = 1'b1;
            cfg_pe  = 2'(i);
            cfg_lit = LIT_W'(5);
            cfg_ptr = PTR_W'(8'h10 + i);
            tick();
        end
        cfg_we    = 1'b0;
        dec_valid = 1'b1;
        dec_lit   = LIT_W'(5);
        #1;
        chk("d5_ready", 64'(dec_ready), 64'(1));
        expect_bcast(LIT_W'(5), 32'h13121110);
        tick();
        dec_valid = 1'b0;
        #1;
        chk("d5_valid", 64'(newLitValid),   64'(1));
        chk("d5_lit",   64'(newLit),        64'(5));
        chk("d5_ptrs",  64'(newLitHeadPtr), 64'h13121110);
        chk("d5_busy",  64'(quiescent),     64'(0));
        tick();
        chk("d5_idle_valid", 64'(newLitValid), 64'(0));
        chk("d5_quiesc",     64'(quiescent),   64'(1));
        chk("d5_sb_empty",   64'(sb.size()),   64'(0));

        // two engines imply the same literal -3
        pe_imply_lit[0*LIT_W +: LIT_W] = neg_lit(3);
        pe_imply_lit[2*LIT_W +: LIT_W] = neg_lit(3);
        pe_imply_valid = 4'b0101;
        expect_bcast(neg_lit(3), '0);
        #1;
        chk("dup_halt0", 64'(pe_halt), 64'(0));
        tick();
        pe_imply_valid = '0;
        #1;
        chk("dup_halt1", 64'(pe_halt), 64'(1));
        tick();
        chk("dup_halt2", 64'(pe_halt), 64'(1));
        tick();
        chk("dup_halt3", 64'(pe_halt), 64'(0));
        repeat (3) tick();
        chk("dup_sb_empty", 64'(sb.size()), 64'(0));

        // complementary implications 7 / -7 raise a conflict
        newLitAccept = '0;
        pe_imply_lit[1*LIT_W +: LIT_W] = LIT_W'(7);
        pe_imply_lit[3*LIT_W +: LIT_W] = neg_lit(7);
        pe_imply_valid = 4'b1010;
        tick();
        pe_imply_valid = '0;
        tick();
        tick();
        chk("cf_conflict", 64'(conflict),    64'(1));
        chk("cf_valid",    64'(newLitValid), 64'(0));
        chk("cf_halt",     64'(pe_halt),     64'(1));
        chk("cf_ready",    64'(dec_ready),   64'(0));
        clr = 1'b1;
        tick();
        clr          = 1'b0;
        newLitAccept = '1;
        #1;
        chk("clr_conflict", 64'(conflict),  64'(0));
        chk("clr_quiesc",   64'(quiescent), 64'(1));
        chk("clr_halt",     64'(pe_halt),   64'(0));
        dec_valid = 1'b1;
        dec_lit   = LIT_W'(7);
        #1;
        chk("d7_ready", 64'(dec_ready), 64'(1));
        expect_bcast(LIT_W'(7), '0);
        tick();
        dec_valid = 1'b0;
        #1;
        chk("d7_valid", 64'(newLitValid), 64'(1));
        tick();
        tick();
        chk("d7_sb_empty", 64'(sb.size()), 64'(0));

        // fill the queue with accept held low, then hold an implication in a slot
        newLitAccept = '0;
        for (int k = 0; k < 8; k++) begin
            dec_valid = 1'b1;
            dec_lit   = LIT_W'(10 + k);
            #1;
            chk("fill_ready", 64'(dec_ready), 64'(1));
            expect_bcast(LIT_W'(10 + k), '0);
            tick();
        end
        dec_valid = 1'b0;
        #1;
        chk("full_ready", 64'(dec_ready), 64'(0));
        pe_imply_lit[1*LIT_W +: LIT_W] = LIT_W'(20);
        pe_imply_valid = 4'b0010;
        expect_bcast(LIT_W'(20), '0);
        tick();
        pe_imply_valid = '0;
        #1;
        chk("held_halt", 64'(pe_halt), 64'(1));
        repeat (3) tick();
        chk("held_halt_late", 64'(pe_halt), 64'(1));
        chk("held_head",      64'(newLit),  64'(10));
        newLitAccept = '1;
        repeat (12) tick();
        chk("drain_sb_empty", 64'(sb.size()),  64'(0));
        chk("drain_halt",     64'(pe_halt),    64'(0));
        chk("drain_quiesc",   64'(quiescent),  64'(1));

        // engine conflict with three entries queued flushes the queue
        newLitAccept = '0;
        for (int k = 0; k < 3; k++) begin
            dec_valid = 1'b1;
            dec_lit   = LIT_W'(30 + k);
            expect_bcast(LIT_W'(30 + k), '0);
            tick();
        end
        dec_valid   = 1'b0;
        pe_conflict = 4'b0100;
        tick();
        pe_conflict = '0;
        #1;
        chk("pc_conflict", 64'(conflict),    64'(1));
        chk("pc_valid",    64'(newLitValid), 64'(0));
        sb.delete();
        clr = 1'b1;
        tick();
        clr          = 1'b0;
        newLitAccept = '1;
        dec_valid    = 1'b1;
        dec_lit      = LIT_W'(40);
        expect_bcast(LIT_W'(40), '0);
        tick();
        dec_valid = 1'b0;
        tick();
        tick();
        chk("pc_flushed", 64'(sb.size()), 64'(0));

        // async reset in the middle of a run
        newLitAccept = '0;
        dec_valid    = 1'b1;
        dec_lit      = LIT_W'(41);
        tick();
        dec_lit        = LIT_W'(42);
        pe_imply_lit[0*LIT_W +: LIT_W] = LIT_W'(43);
        pe_imply_valid = 4'b0001;
        tick();
        dec_valid      = 1'b0;
        pe_imply_valid = '0;
        #1;
        chk("mr_valid", 64'(newLitValid), 64'(1));
        chk("mr_halt",  64'(pe_halt),     64'(1));
        rst_n        = 1'b1;
        newLitAccept = '1;
        #1;
        chk("ar_valid",  64'(newLitValid), 64'(0));
        chk("ar_halt",   64'(pe_halt),     64'(0));
        chk("ar_ready",  64'(dec_ready),   64'(1));
        chk("ar_conf",   64'(conflict),    64'(0));
        chk("ar_quiesc", 64'(quiescent),   64'(1));
        tick();
        rst_n = 1'b0;
        tick();

        // reset also cleared the head table and the bitmap
        dec_valid = 1'b1;
        dec_lit   = LIT_W'(5);
        expect_bcast(LIT_W'(5), '0);
        tick();
        dec_valid = 1'b0;
        #1;
        chk("tbl_cleared", 64'(newLitHeadPtr), 64'(0));
        tick();
        tick();
        chk("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
